// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-channel arbitrating multiplexer.
// Picks one valid requester per cycle by round-robin or by fixed priority,
// with an optional forced-channel override. The winning word is held in a
// single output register that has a valid/ready handshake.

module arb_mux_n #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int RR_MODE  = 1,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SEL_W-1:0]     rr_ptr;
    logic [SEL_W-1:0]     ptr_next;
    logic [CHANNELS-1:0]  eligible;
    logic                 grant_found;
    logic [SEL_W-1:0]     grant_idx;
    logic                 load_ok;
    logic                 xfer;
    logic [WIDTH-1:0]     sel_data;

    assign out_valid = (state == FULL);

    // The register can take a new word when it is empty or being drained
    // this cycle; nothing is accepted while reset is held.
    assign load_ok = !out_valid || out_ready;
    assign xfer    = grant_found && load_ok && !reset;

    // A forced index outside the channel range matches no bit, so nothing is eligible.
    always_comb begin
        eligible = '0;
        if (!force_en) begin
            eligible = in_valid;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (int'(force_sel) == k) begin
                    eligible[k] = in_valid[k];
                end
            end
        end
    end

    // Search for the winner: upward from rr_ptr with wrap, or from index 0 in fixed priority.
    always_comb begin : grant_search
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (RR_MODE != 0) ? int'(rr_ptr) + i : i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

    // Only the granted channel sees ready, and only on an actual transfer.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

    // The pointer wraps at CHANNELS, which matters when CHANNELS is not a power of two.
    assign ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);

    // Output register state: fill on any transfer, empty on a drain with no refill.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (xfer) state_nxt = FULL;
            FULL:  if (out_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // State register; an asynchronous reset discards any held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Data path: capture the winner and advance the fairness pointer, except on forced picks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_chan <= '0;
            rr_ptr   <= '0;
        end else if (xfer) begin
            out_data <= sel_data;
            out_chan <= grant_idx;
            if (!force_en) begin
                rr_ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: directed self-checking bench for arb_mux_n.
// Three instances: default round-robin (4 x 64), fixed priority (4 x 64),
// and a non-power-of-two round-robin variant (3 x 5).

module tb_arb_mux_n;

    logic clk;
    logic reset;

    // Round-robin, 4 channels, 64 bits
    logic [4*64-1:0] rrData;
    logic [3:0]      rrValid;
    logic [3:0]      rrReady;
    logic            rrForceEn;
    logic [1:0]      rrForceSel;
    logic [63:0]     rrOutData;
    logic [1:0]      rrOutChan;
    logic            rrOutValid;
    logic            rrOutReady;

    // Fixed priority, 4 channels, 64 bits
    logic [4*64-1:0] fpData;
    logic [3:0]      fpValid;
    logic [3:0]      fpReady;
    logic [63:0]     fpOutData;
    logic [1:0]      fpOutChan;
    logic            fpOutValid;
    logic            fpOutReady;

    // Round-robin, 3 channels, 5 bits
    logic [3*5-1:0]  n3Data;
    logic [2:0]      n3Valid;
    logic [2:0]      n3Ready;
    logic            n3ForceEn;
    logic [1:0]      n3ForceSel;
    logic [4:0]      n3OutData;
    logic [1:0]      n3OutChan;
    logic            n3OutValid;
    logic            n3OutReady;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [3:0]  iv;
        logic        ordy;
        logic        fen;
        logic [1:0]  fsel;
        logic [3:0]  expReady;
        logic        expValid;
        logic [1:0]  expChan;
        logic [63:0] expData;
    } vec_t;

    vec_t vecs[16];

    arb_mux_n #(.WIDTH(64), .CHANNELS(4), .RR_MODE(1)) dutRr (
        .clk(clk), .reset(reset), .in_data(rrData), .in_valid(rrValid),
        .in_ready(rrReady), .force_en(rrForceEn), .force_sel(rrForceSel),
        .out_data(rrOutData), .out_chan(rrOutChan), .out_valid(rrOutValid),
        .out_ready(rrOutReady)
    );

    arb_mux_n #(.WIDTH(64), .CHANNELS(4), .RR_MODE(0)) dutFp (
        .clk(clk), .reset(reset), .in_data(fpData), .in_valid(fpValid),
        .in_ready(fpReady), .force_en(1'b0), .force_sel(2'd0),
        .out_data(fpOutData), .out_chan(fpOutChan), .out_valid(fpOutValid),
        .out_ready(fpOutReady)
    );

    arb_mux_n #(.WIDTH(5), .CHANNELS(3), .RR_MODE(1)) dutN3 (
        .clk(clk), .reset(reset), .in_data(n3Data), .in_valid(n3Valid),
        .in_ready(n3Ready), .force_en(n3ForceEn), .force_sel(n3ForceSel),
        .out_data(n3OutData), .out_chan(n3OutChan), .out_valid(n3OutValid),
        .out_ready(n3OutReady)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Applies one table row at a falling edge, checks in_ready, then checks the register after the next rising edge
    task automatic applyStimulus(input int idx);
        rrValid    = vecs[idx].iv;
        rrOutReady = vecs[idx].ordy;
        rrForceEn  = vecs[idx].fen;
        rrForceSel = vecs[idx].fsel;
        #1;
        checkOutput($sformatf("row%0d in_ready", idx), 64'(rrReady), 64'(vecs[idx].expReady));
        @(negedge clk);
        checkOutput($sformatf("row%0d out_valid", idx), 64'(rrOutValid), 64'(vecs[idx].expValid));
        checkOutput($sformatf("row%0d out_chan", idx), 64'(rrOutChan), 64'(vecs[idx].expChan));
        checkOutput($sformatf("row%0d out_data", idx), rrOutData, vecs[idx].expData);
    endtask

    initial begin
        logic [1:0] n3ExpChan [4];
        logic [4:0] n3ExpData [4];

        //            iv      ordy  fen   fsel   expReady valid chan   data
        vecs[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 64'd1};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 64'd2};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 64'd3};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 64'd4};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 64'd1};
        vecs[5]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 64'd1};
        vecs[6]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 64'd1};
        vecs[7]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 64'd1};
        vecs[8]  = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 64'd3};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, 64'd3};
        vecs[10] = '{4'b0101, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd2, 64'd3};
        vecs[11] = '{4'b0111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1, 64'd2};
        vecs[12] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 64'd4};
        vecs[13] = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 64'd1};
        vecs[14] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 64'd1};
        vecs[15] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 64'd1};

        n3ExpChan[0] = 2'd0; n3ExpChan[1] = 2'd1; n3ExpChan[2] = 2'd2; n3ExpChan[3] = 2'd0;
        n3ExpData[0] = 5'h1F; n3ExpData[1] = 5'h12; n3ExpData[2] = 5'h05; n3ExpData[3] = 5'h1F;

        for (int k = 0; k < 4; k++) begin
            rrData[k*64 +: 64] = 64'(k + 1);
            fpData[k*64 +: 64] = 64'(256 + k);
        end
        n3Data = {5'h05, 5'h12, 5'h1F};

        reset = 1'b1;
        rrValid = 4'b1111; rrOutReady = 1'b1; rrForceEn = 1'b0; rrForceSel = 2'd0;
        fpValid = 4'b0000; fpOutReady = 1'b1;
        n3Valid = 3'b000;  n3OutReady = 1'b1; n3ForceEn = 1'b0; n3ForceSel = 2'd0;

        // Reset state
        #12;
        checkOutput("reset out_valid", 64'(rrOutValid), 64'd0);
        checkOutput("reset out_data", rrOutData, 64'd0);
        checkOutput("reset out_chan", 64'(rrOutChan), 64'd0);
        checkOutput("reset in_ready", 64'(rrReady), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin, back-pressure, force select, hold and drain
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i);
        end

        // Reset while FULL discards the held word and clears the pointer
        rrData[63:0] = 64'hDEAD;
        rrValid = 4'b0001; rrOutReady = 1'b1;
        @(negedge clk);
        checkOutput("dead load valid", 64'(rrOutValid), 64'd1);
        checkOutput("dead load data", rrOutData, 64'hDEAD);
        rrValid = 4'b0000; rrOutReady = 1'b0;
        @(negedge clk);
        checkOutput("dead hold data", rrOutData, 64'hDEAD);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset valid", 64'(rrOutValid), 64'd0);
        checkOutput("async reset data", rrOutData, 64'd0);
        checkOutput("async reset chan", 64'(rrOutChan), 64'd0);
        rrValid = 4'b1111; rrOutReady = 1'b1;
        #1;
        checkOutput("in_ready during reset", 64'(rrReady), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rr_ptr cleared grant", 64'(rrReady), 64'b0001);
        @(negedge clk);
        checkOutput("post reset chan", 64'(rrOutChan), 64'd0);
        checkOutput("post reset data", rrOutData, 64'hDEAD);
        rrValid = 4'b0000;

        // Fixed priority: channel 1 always beats channel 3
        for (int i = 0; i < 4; i++) begin
            fpValid = 4'b1010;
            #1;
            checkOutput($sformatf("fp%0d in_ready", i), 64'(fpReady), 64'b0010);
            @(negedge clk);
            checkOutput($sformatf("fp%0d out_chan", i), 64'(fpOutChan), 64'd1);
            checkOutput($sformatf("fp%0d out_data", i), fpOutData, 64'h101);
        end
        fpValid = 4'b1000;
        #1;
        checkOutput("fp alone in_ready", 64'(fpReady), 64'b1000);
        @(negedge clk);
        checkOutput("fp alone out_chan", 64'(fpOutChan), 64'd3);
        fpValid = 4'b0000;

        // Three channels: pointer wraps at 3, 5-bit data passes intact
        for (int i = 0; i < 4; i++) begin
            n3Valid = 3'b111;
            #1;
            checkOutput($sformatf("n3_%0d in_ready", i), 64'(n3Ready), 64'(3'b001 << n3ExpChan[i]));
            @(negedge clk);
            checkOutput($sformatf("n3_%0d out_chan", i), 64'(n3OutChan), 64'(n3ExpChan[i]));
            checkOutput($sformatf("n3_%0d out_data", i), 64'(n3OutData), 64'(n3ExpData[i]));
        end

        // Forced index beyond the channel range grants nothing
        n3ForceEn = 1'b1; n3ForceSel = 2'd3;
        #1;
        checkOutput("n3 force oob in_ready", 64'(n3Ready), 64'd0);
        @(negedge clk);
        checkOutput("n3 force oob out_valid", 64'(n3OutValid), 64'd0);
        n3ForceEn = 1'b0; n3Valid = 3'b000;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
